// File: rtl/key_debounce.sv
// Keyboard front end: synchronises, debounces and registers NKEYS raw buttons into a clean
// chord bus, with a one-cycle change strobe and a lowest-key-first monophonic note index.
module key_debounce #(
    parameter int unsigned NKEYS           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    localparam int unsigned IDX_W          = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] chord,
    output logic             chord_chg,
    output logic             note_on,
    output logic [IDX_W-1:0] note_idx
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NKEYS-1:0] POL_MASK = {NKEYS{KEY_ACTIVE_LOW}};

    generate
        if (((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) || (DEBOUNCE_CYCLES < 2)) begin : g_param_check
            $error("key_debounce: CNT_W too narrow for DEBOUNCE_CYCLES, or DEBOUNCE_CYCLES < 2");
        end
    endgenerate

    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] chord_nxt;
    logic [CNT_W-1:0] cnt     [NKEYS];
    logic [CNT_W-1:0] cnt_nxt [NKEYS];
    logic [IDX_W-1:0] idx_nxt;
    logic             idx_found;

    // Per-key stability counters; any agreement with the stable level restarts the count.
    always_comb begin
        chord_nxt = chord;
        idx_nxt   = '0;
        idx_found = 1'b0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != chord[i]) begin
                if (cnt[i] == TERM_CNT) begin
                    chord_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        // Lowest pressed key wins
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (chord_nxt[i] && !idx_found) begin
                idx_nxt   = IDX_W'(i);
                idx_found = 1'b1;
            end
        end
    end

    // Status outputs are derived from chord_nxt so they move on the same edge as chord.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            chord     <= '0;
            chord_chg <= 1'b0;
            note_on   <= 1'b0;
            note_idx  <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= key_raw ^ POL_MASK;
            sync2     <= sync1;
            chord     <= chord_nxt;
            chord_chg <= (chord_nxt != chord);
            note_on   <= |chord_nxt;
            note_idx  <= idx_nxt;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity, every cycle compared
// against a sliding-window debounce model built from the raw input history.
module tb_key_debounce;

    localparam int unsigned NK   = 8;
    localparam int unsigned DB   = 4;
    localparam int unsigned CW   = 3;
    localparam int          MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_raw;
    logic [7:0] chord;
    logic       chord_chg;
    logic       note_on;
    logic [2:0] note_idx;

    key_debounce #(
        .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw),
        .chord(chord), .chord_chg(chord_chg), .note_on(note_on), .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    // Model history: pressed level sampled at each edge and whether reset was held there.
    logic [7:0] p_h [MAXC];
    bit         r_h [MAXC];
    int         t = 0;
    int         last_flip [8];
    logic [7:0] m_chord = 8'h00;
    logic       m_chg   = 1'b0;
    int         errors  = 0;
    int         checks  = 0;
    int         chg_cnt = 0;

    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // A key flips once its synchronised level has disagreed with the stable level on each of
    // the last DB edges, none of them in reset, and it has not flipped inside that window.
    task automatic model_edge();
        logic [7:0] nxt;
        logic       s2;
        bit         all_diff;
        int         tk;
        nxt = m_chord;
        if (r_h[t]) begin
            nxt = 8'h00;
            for (int i = 0; i < 8; i++) last_flip[i] = t;
        end else begin
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < int'(DB); k++) begin
                    tk = t - k;
                    if (tk < 2) begin
                        all_diff = 1'b0;
                    end else begin
                        s2 = (r_h[tk-1] || r_h[tk-2]) ? 1'b0 : p_h[tk-2][i];
                        if (r_h[tk] || (s2 == m_chord[i])) all_diff = 1'b0;
                    end
                end
                if (all_diff && (t - last_flip[i] >= int'(DB))) begin
                    nxt[i]       = ~m_chord[i];
                    last_flip[i] = t;
                end
            end
        end
        m_chg   = r_h[t] ? 1'b0 : (nxt != m_chord);
        m_chord = nxt;
    endtask

    task automatic step(input logic [7:0] raw, input logic rn);
        key_raw = raw;
        rst_n   = rn;
        @(posedge clk);
        p_h[t] = ~raw;
        r_h[t] = !rn;
        model_edge();
        #1;
        check8("chord", chord, m_chord);
        check8("chord_chg", 8'(chord_chg), 8'(m_chg));
        check8("note_on", 8'(note_on), 8'(|m_chord));
        check8("note_idx", 8'(note_idx), 8'(low_idx(m_chord)));
        if (chord_chg === 1'b1) chg_cnt++;
        t++;
    endtask

    task automatic run(input logic [7:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b1);
    endtask

    initial begin
        logic [7:0] v;
        int         len;
        for (int i = 0; i < 8; i++) last_flip[i] = -100;
        rst_n   = 1'b0;
        key_raw = 8'hFF;

        // Reset
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        check8("rst_chord", chord, 8'h00);
        check8("rst_chg", 8'(chord_chg), 8'h00);
        check8("rst_note_on", 8'(note_on), 8'h00);
        check8("rst_note_idx", 8'(note_idx), 8'h00);
        run(8'hFF, 6);

        // Clean press and release of key 2
        chg_cnt = 0;
        run(8'hFB, 5);
        check8("press_early", chord, 8'h00);
        run(8'hFB, 1);
        check8("press_chord", chord, 8'h04);
        check8("press_chg", 8'(chord_chg), 8'h01);
        check8("press_note_on", 8'(note_on), 8'h01);
        check8("press_idx", 8'(note_idx), 8'h02);
        run(8'hFB, 4);
        check8("press_pulses", 8'(chg_cnt), 8'h01);
        chg_cnt = 0;
        run(8'hFF, 5);
        check8("release_early", chord, 8'h04);
        run(8'hFF, 1);
        check8("release_chord", chord, 8'h00);
        check8("release_chg", 8'(chord_chg), 8'h01);
        run(8'hFF, 4);
        check8("release_pulses", 8'(chg_cnt), 8'h01);

        // Bounce on key 0 never qualifies
        chg_cnt = 0;
        for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 8'hFE : 8'hFF, 1'b1);
        run(8'hFF, 10);
        check8("bounce_chord", chord, 8'h00);
        check8("bounce_pulses", 8'(chg_cnt), 8'h00);

        // Two-key chord, then partial release
        chg_cnt = 0;
        run(8'hD7, 10);
        check8("chord_val", chord, 8'h28);
        check8("chord_idx", 8'(note_idx), 8'h03);
        check8("chord_pulses", 8'(chg_cnt), 8'h01);
        chg_cnt = 0;
        run(8'hDF, 10);
        check8("partial_val", chord, 8'h20);
        check8("partial_idx", 8'(note_idx), 8'h05);
        check8("partial_pulses", 8'(chg_cnt), 8'h01);
        run(8'hFF, 10);

        // Reset mid-debounce with key 7 held through it
        run(8'h7F, 4);
        step(8'h7F, 1'b0);
        step(8'h7F, 1'b0);
        check8("midrst_chord", chord, 8'h00);
        run(8'h7F, 5);
        check8("redetect_early", chord, 8'h00);
        run(8'h7F, 1);
        check8("redetect_chord", chord, 8'h80);
        run(8'hFF, 10);

        // Staggered presses on consecutive edges
        chg_cnt = 0;
        step(8'hFE, 1'b1);
        run(8'hFC, 4);
        run(8'hFC, 1);
        check8("stag_first", chord, 8'h01);
        check8("stag_first_chg", 8'(chord_chg), 8'h01);
        run(8'hFC, 1);
        check8("stag_second", chord, 8'h03);
        check8("stag_second_chg", 8'(chord_chg), 8'h01);
        check8("stag_idx", 8'(note_idx), 8'h00);
        run(8'hFC, 4);
        check8("stag_pulses", 8'(chg_cnt), 8'h02);
        run(8'hFF, 10);

        // Random key activity with occasional resets
        v = 8'hFF;
        for (int s = 0; s < 120; s++) begin
            v   = v ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            len = int'($urandom_range(8, 1));
            if ($urandom_range(39, 0) == 0) begin
                for (int i = 0; i < 2; i++) step(v, 1'b0);
            end
            run(v, len);
        end
        run(8'hFF, 12);
        check8("final_idle", chord, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
